// File: rtl/pong_tick_scheduler.sv
// Pong tick scheduler: services the interval timer over Avalon-MM and fans each timeout out to per-channel divided ticks.
// Optional feature macro: PONG_TICK_SNAPSHOT_EN (timer snapshot after each service).

module pong_tick_channel #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             cfg_hit,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;

  // A config write in the step cycle takes priority and suppresses that step's tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cfg_hit) begin
        div <= cfg_div;
        cnt <= '0;
      end else if (step && div != '0) begin
        if (cnt == div - DIV_W'(1)) begin
          tick <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end
endmodule

module pong_tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              timer_irq,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick_o,
  output logic [31:0]       service_count_o,
`ifdef PONG_TICK_SNAPSHOT_EN
  output logic [15:0]       snapshot_o,
`endif
  output logic              busy_o
);
  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CLEAR,
`ifdef PONG_TICK_SNAPSHOT_EN
    SNAP,
    SREAD,
    SCAPT,
`endif
    DISPATCH
  } state_t;

  state_t state, state_n;

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  // Bus outputs are a pure decode of the state register.
  always_comb begin
    state_n      = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 3'd0;
    m_writedata  = 16'h0000;
    case (state)
      INIT: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = 16'h0001;
        state_n      = IDLE;
      end
      IDLE: if (timer_irq) state_n = CLEAR;
      CLEAR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        state_n      = DISPATCH;
      end
`ifdef PONG_TICK_SNAPSHOT_EN
      DISPATCH: state_n = SNAP;
      SNAP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd4;
        state_n      = SREAD;
      end
      SREAD: begin
        m_chipselect = 1'b1;
        m_address    = 3'd4;
        state_n      = SCAPT;
      end
      SCAPT: state_n = IDLE;
`else
      DISPATCH: state_n = IDLE;
`endif
      default: state_n = INIT;
    endcase
  end

  assign busy_o = (state != IDLE);

  logic step;
  assign step = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset)     service_count_o <= 32'd0;
    else if (step) service_count_o <= service_count_o + 32'd1;
  end

`ifdef PONG_TICK_SNAPSHOT_EN
  // Readdata for the SREAD address is valid in SCAPT.
  always_ff @(posedge clk) begin
    if (reset)               snapshot_o <= 16'h0000;
    else if (state == SCAPT) snapshot_o <= m_readdata;
  end
`else
  logic unused_readdata;
  assign unused_readdata = ^m_readdata;
`endif

  // Channel indices at or above NUM_CH never match, so those writes drop.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pong_tick_channel #(.DIV_W(DIV_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .step    (step),
      .cfg_hit (cfg_we && (cfg_ch == 3'(i))),
      .cfg_div (cfg_div),
      .tick    (tick_o[i])
    );
  end
endmodule
